axi_read_arbiter: RTL and testbench

//  Shares the single AXI read channel (AR/R) between the instruction cache (requester 0) and the

---
 rtl/axi_read_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_read_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between the icache (0) and dcache (1).
// One complete burst is in flight at a time; R beats are steered back to the granted requester.
module axi_read_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_BASE    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_arvalid,
    input  logic [1:0][ADDR_WIDTH-1:0] req_araddr,
    input  logic [1:0][7:0]            req_arlen,
    input  logic [1:0][1:0]            req_arburst,
    output logic [1:0]                 req_arready,
    output logic [1:0]                 req_rvalid,
    input  logic [1:0]                 req_rready,
    output logic [DATA_WIDTH-1:0]      req_rdata,
    output logic [1:0]                 req_rresp,
    output logic                       req_rlast,
    output logic [ID_WIDTH-1:0]        m_axi_arid,
    output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arlock,
    output logic [3:0]                 m_axi_arcache,
    output logic [2:0]                 m_axi_arprot,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [ID_WIDTH-1:0]        m_axi_rid,
    input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [7:0]              arlen_q, arlen_d;
    logic [1:0]              arburst_q, arburst_d;
    logic [ID_WIDTH-1:0]     arid_q, arid_d;
    logic                    winner;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 8'd0;
            araddr_q     <= '0;
            arlen_q      <= 8'd0;
            arburst_q    <= 2'd0;
            arid_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arburst_q    <= arburst_d;
            arid_q       <= arid_d;
        end
    end

    // With both requesting, the one not served last wins; otherwise the sole requester.
    assign winner = (req_arvalid == 2'b11) ? ~last_grant_q : req_arvalid[1];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        arburst_d     = arburst_q;
        arid_d        = arid_q;
        req_arready   = 2'b00;
        req_rvalid    = 2'b00;
        req_rdata     = '0;
        req_rresp     = 2'd0;
        req_rlast     = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req_arvalid) begin
                    araddr_d     = req_araddr[winner];
                    arlen_d      = req_arlen[winner];
                    arburst_d    = req_arburst[winner];
                    arid_d       = ID_WIDTH'(ID_BASE) + ID_WIDTH'(winner);
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    req_arready[grant_q] = 1'b1;
                    beat_cnt_d           = 8'd0;
                    state_d              = DATA;
                end
            end
            DATA: begin
                m_axi_rready        = req_rready[grant_q];
                req_rvalid[grant_q] = m_axi_rvalid;
                req_rdata           = m_axi_rdata;
                req_rresp           = m_axi_rresp;
                req_rlast           = m_axi_rlast;
                if (m_axi_rvalid && req_rready[grant_q]) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (m_axi_rlast) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arburst = arburst_q;
    assign m_axi_arsize  = 3'd3;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign busy          = (state_q != IDLE);

    // Protocol sanity checks on the returning R stream; ignored by synthesis.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == DATA && m_axi_rvalid) begin
                assert (m_axi_rid == arid_q)
                    else $error("rid %0d does not match granted id %0d", m_axi_rid, arid_q);
            end
            if (state_q == DATA && m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                assert (beat_cnt_q == arlen_q)
                    else $error("rlast on beat %0d, arlen %0d", beat_cnt_q, arlen_q);
            end
            assert (!(state_q != DATA && m_axi_rvalid))
                else $error("rvalid outside a data phase");
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized bench for axi_read_arbiter: transaction-level requester queues, a bus slave
// and a reference arbiter that predicts every output each cycle.
module tb_axi_read_arbiter;
    localparam int IDW = 13;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic [1:0]         req_arvalid;
    logic [1:0][AW-1:0] req_araddr;
    logic [1:0][7:0]    req_arlen;
    logic [1:0][1:0]    req_arburst;
    logic [1:0]         req_arready;
    logic [1:0]         req_rvalid;
    logic [1:0]         req_rready;
    logic [DW-1:0]      req_rdata;
    logic [1:0]         req_rresp;
    logic               req_rlast;
    logic [IDW-1:0]     m_axi_arid;
    logic [AW-1:0]      m_axi_araddr;
    logic [7:0]         m_axi_arlen;
    logic [2:0]         m_axi_arsize;
    logic [1:0]         m_axi_arburst;
    logic               m_axi_arlock;
    logic [3:0]         m_axi_arcache;
    logic [2:0]         m_axi_arprot;
    logic               m_axi_arvalid;
    logic               m_axi_arready;
    logic [IDW-1:0]     m_axi_rid;
    logic [DW-1:0]      m_axi_rdata;
    logic [1:0]         m_axi_rresp;
    logic               m_axi_rlast;
    logic               m_axi_rvalid;
    logic               m_axi_rready;
    logic               busy;

    axi_read_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_BASE(0)) dut (
        .clk(clk), .reset(reset),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arburst(req_arburst), .req_arready(req_arready), .req_rvalid(req_rvalid),
        .req_rready(req_rready), .req_rdata(req_rdata), .req_rresp(req_rresp),
        .req_rlast(req_rlast), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } burst_t;

    burst_t q0[$];
    burst_t q1[$];
    int     glog[$];

    // Reference: phase 0 = nobody owns the bus, 1 = owner's address pending, 2 = owner's beats.
    int ph, own, lastg, rem;
    int rv_pct, ar_pct, ar_wait;
    int rr_pct[2];
    bit rr_toggle, tog, after_rst;
    int obs_beats[2];
    int total, bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void push_req(input int who, input logic [63:0] a,
                                     input logic [7:0] l, input logic [1:0] b);
        burst_t t;
        t.addr = a; t.len = l; t.burst = b;
        if (who == 0) q0.push_back(t); else q1.push_back(t);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_arvalid = 2'b00; req_araddr = '0; req_arlen = '0; req_arburst = '0;
        req_rready = 2'b00; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
        m_axi_rlast = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = 2'd0;
        q0.delete(); q1.delete();
        ph = 0; own = 0; lastg = 1; rem = 0; ar_wait = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        after_rst = 1'b1;
    endtask

    // One clock: drive at posedge+1, check at the falling edge, advance the reference.
    task automatic cycle();
        burst_t hd;
        logic [1:0] exp_arr, exp_rv;
        req_arvalid[0] = (q0.size() != 0);
        req_arvalid[1] = (q1.size() != 0);
        req_araddr = '0; req_arlen = '0; req_arburst = '0;
        if (q0.size() != 0) begin
            req_araddr[0] = q0[0].addr; req_arlen[0] = q0[0].len; req_arburst[0] = q0[0].burst;
        end
        if (q1.size() != 0) begin
            req_araddr[1] = q1[0].addr; req_arlen[1] = q1[0].len; req_arburst[1] = q1[0].burst;
        end
        tog = ~tog;
        for (int i = 0; i < 2; i++)
            req_rready[i] = rr_toggle ? tog : ($urandom_range(99) < rr_pct[i]);
        if (ph == 1 && ar_wait > 0) begin
            m_axi_arready = 1'b0;
            ar_wait--;
        end else begin
            m_axi_arready = ($urandom_range(99) < ar_pct);
        end
        if (ph == 2) begin
            m_axi_rvalid = ($urandom_range(99) < rv_pct);
            m_axi_rdata  = {$urandom, $urandom};
            m_axi_rresp  = 2'($urandom_range(3));
            m_axi_rlast  = (rem == 1);
            m_axi_rid    = IDW'(own);
        end else begin
            m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'd0;
            m_axi_rlast = 1'b0; m_axi_rid = '0;
        end

        #4;
        if (after_rst) begin
            check_eq("rst_arid", m_axi_arid, 0);
            check_eq("rst_araddr", m_axi_araddr, 0);
            check_eq("rst_arlen", m_axi_arlen, 0);
            check_eq("rst_arburst", m_axi_arburst, 0);
            after_rst = 1'b0;
        end
        check_eq("busy", busy, ph != 0);
        check_eq("arvalid", m_axi_arvalid, ph == 1);
        if (ph == 1) begin
            hd = (own == 0) ? q0[0] : q1[0];
            check_eq("araddr", m_axi_araddr, hd.addr);
            check_eq("arlen", m_axi_arlen, hd.len);
            check_eq("arburst", m_axi_arburst, hd.burst);
            check_eq("arid", m_axi_arid, own);
            check_eq("arsize", m_axi_arsize, 3);
        end
        exp_arr = (ph == 1 && m_axi_arready) ? 2'(1 << own) : 2'b00;
        exp_rv  = (ph == 2 && m_axi_rvalid) ? 2'(1 << own) : 2'b00;
        check_eq("req_arready", req_arready, exp_arr);
        check_eq("req_rvalid", req_rvalid, exp_rv);
        check_eq("rready", m_axi_rready, (ph == 2) ? req_rready[own] : 1'b0);
        if (ph == 2 && m_axi_rvalid) begin
            check_eq("rdata", req_rdata, m_axi_rdata);
            check_eq("rresp", req_rresp, m_axi_rresp);
            check_eq("rlast", req_rlast, m_axi_rlast);
        end
        for (int i = 0; i < 2; i++)
            if (req_rvalid[i] && req_rready[i]) obs_beats[i]++;

        case (ph)
            0: if (q0.size() != 0 || q1.size() != 0) begin
                   if (q0.size() != 0 && q1.size() != 0) own = 1 - lastg;
                   else own = (q0.size() != 0) ? 0 : 1;
                   lastg = own;
                   ph = 1;
               end
            1: if (m_axi_arready) begin
                   hd = (own == 0) ? q0.pop_front() : q1.pop_front();
                   rem = int'(hd.len) + 1;
                   glog.push_back(own);
                   ph = 2;
               end
            default: if (m_axi_rvalid && req_rready[own]) begin
                   rem--;
                   if (rem == 0) ph = 0;
               end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((ph != 0 || q0.size() != 0 || q1.size() != 0) && n < limit) begin
            cycle();
            n++;
        end
        check_eq(tag, (n < limit) ? 1 : 0, 1);
        cycle();
    endtask

    initial begin
        int n, pushed;
        total = 0; bad = 0; tog = 1'b0; rr_toggle = 1'b0; after_rst = 1'b0;
        rv_pct = 100; ar_pct = 100; rr_pct[0] = 100; rr_pct[1] = 100;
        do_reset();
        cycle();

        // Icache alone, WRAP burst of 8.
        obs_beats[0] = 0; obs_beats[1] = 0;
        push_req(0, 64'h1000, 8'd7, 2'd2);
        drain("t1_drain", 200);
        check_eq("t1_beats0", obs_beats[0], 8);
        check_eq("t1_beats1", obs_beats[1], 0);

        // Both requesting together straight from reset.
        do_reset();
        glog.delete();
        push_req(0, 64'h1040, 8'd3, 2'd2);
        push_req(1, 64'h2000, 8'd3, 2'd1);
        drain("t2_drain", 200);
        check_eq("t2_ngrant", glog.size(), 2);
        check_eq("t2_first", glog[0], 0);
        check_eq("t2_second", glog[1], 1);

        // Four back-to-back contended bursts alternate.
        glog.delete();
        for (int i = 0; i < 2; i++) begin
            push_req(0, 64'h3000 + 64'(i * 64), 8'd3, 2'd2);
            push_req(1, 64'h4000 + 64'(i * 64), 8'd1, 2'd1);
        end
        drain("t3_drain", 300);
        check_eq("t3_ngrant", glog.size(), 4);
        for (int i = 0; i < glog.size(); i++) check_eq("t3_order", glog[i], i % 2);

        // Slow arready, toggling rready.
        obs_beats[1] = 0;
        ar_wait = 5; rr_toggle = 1'b1;
        push_req(1, 64'h5000, 8'd3, 2'd1);
        drain("t4_drain", 200);
        check_eq("t4_beats1", obs_beats[1], 4);
        rr_toggle = 1'b0;

        // Single-beat dcache burst.
        obs_beats[1] = 0;
        push_req(1, 64'h8008, 8'd0, 2'd1);
        drain("t5_drain", 100);
        check_eq("t5_beats1", obs_beats[1], 1);

        // Reset in the middle of a burst after three beats.
        obs_beats[0] = 0;
        push_req(0, 64'h6000, 8'd7, 2'd2);
        n = 0;
        while (obs_beats[0] < 3 && n < 200) begin cycle(); n++; end
        check_eq("t6_reach3", obs_beats[0], 3);
        do_reset();
        glog.delete();
        push_req(1, 64'h7000, 8'd1, 2'd1);
        push_req(0, 64'h7100, 8'd1, 2'd2);
        drain("t6_drain", 200);
        check_eq("t6_first", glog[0], 0);

        // Randomized traffic.
        pushed = 0; n = 0;
        while ((pushed < 40 || ph != 0 || q0.size() != 0 || q1.size() != 0) && n < 20000) begin
            if (pushed < 40 && $urandom_range(9) == 0) begin
                int w;
                w = $urandom_range(1);
                if ((w == 0 ? q0.size() : q1.size()) < 2) begin
                    push_req(w, {32'h0, $urandom} & ~64'h7, 8'($urandom_range(15)),
                             (w == 0) ? 2'd2 : 2'd1);
                    pushed++;
                end
            end
            rv_pct = $urandom_range(100, 40);
            ar_pct = $urandom_range(100, 30);
            rr_pct[0] = $urandom_range(100, 30);
            rr_pct[1] = $urandom_range(100, 30);
            cycle();
            n++;
        end
        check_eq("rand_done", (n < 20000) ? 1 : 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
